// File: rtl/alu_share_arbiter_pkg.sv
// Shared encodings for the ALU sharing arbiter: ALU opcodes, FSM states and
// requester indices, plus a one-hot grant helper.
package alu_share_arbiter_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_SLL = 3'd2,
        ALU_OR  = 3'd3,
        ALU_AND = 3'd4,
        ALU_LTU = 3'd5,
        ALU_LT  = 3'd6,
        ALU_XOR = 3'd7
    } aluOpT;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } stateT;

    localparam int REQ_DP  = 0;
    localparam int REQ_AUX = 1;

    function automatic logic [1:0] oneHot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU shared by both requesters; the zero flag
// reflects the selected result.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
(
    input  aluOpT       op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            // Full 32-bit shift amount: anything >= 32 shifts everything out.
            ALU_SLL: result = b << a;
            ALU_OR:  result = a | b;
            ALU_AND: result = a & b;
            ALU_LTU: result = {31'd0, (a < b)};
            ALU_LT:  result = {31'd0, ($signed(a) < $signed(b))};
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between the main datapath (r0) and an
// auxiliary sequencer (r1); operands are latched at accept, result returned over valid/ready.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int PRIO_RESET = 0,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       r0_op,
    input  logic [2:0]       r1_op,
    input  logic             r0_srca,
    input  logic             r1_srca,
    input  logic             r0_srcb,
    input  logic             r1_srcb,
    input  logic [4:0]       r0_sa,
    input  logic [4:0]       r1_sa,
    input  logic [31:0]      r0_a,
    input  logic [31:0]      r1_a,
    input  logic [31:0]      r0_b,
    input  logic [31:0]      r1_b,
    input  logic [31:0]      r0_imm,
    input  logic [31:0]      r1_imm,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       dbgState
);

    // Handshakes: a transfer happens on a rising edge where both valid[i] and
    // ready[i] are high; valid never waits on ready, and the requester holds
    // its fields stable until that edge.

    stateT       state, nextState;
    logic        prio;
    logic        grant;
    logic [1:0]  readyVec;
    logic        winner;
    logic        accept;
    logic        rspDone;

    aluOpT       opReg;
    logic        srcaReg, srcbReg;
    logic [4:0]  saReg;
    logic [31:0] aReg, bReg, immReg;

    logic [31:0] aluA, aluB, aluResult;
    logic        aluZero;

    always_comb begin
        readyVec = 2'b00;
        if (state == ST_IDLE) begin
            case (req_valid)
                2'b01:   readyVec = 2'b01;
                2'b10:   readyVec = 2'b10;
                2'b11:   readyVec = oneHot(prio);
                default: readyVec = 2'b00;
            endcase
        end
    end

    assign req_ready = readyVec;
    assign winner    = readyVec[REQ_AUX];
    assign accept    = |readyVec;
    assign rspDone   = (state == ST_RESP) && rsp_ready[grant];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: if (accept)  nextState = ST_EXEC;
            ST_EXEC:              nextState = ST_RESP;
            ST_RESP: if (rspDone) nextState = ST_IDLE;
            default:              nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            prio       <= 1'(PRIO_RESET);
            grant      <= 1'b0;
            opReg      <= ALU_ADD;
            srcaReg    <= 1'b0;
            srcbReg    <= 1'b0;
            saReg      <= '0;
            aReg       <= '0;
            bReg       <= '0;
            immReg     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                grant   <= winner;
                opReg   <= aluOpT'(winner ? r1_op : r0_op);
                srcaReg <= winner ? r1_srca : r0_srca;
                srcbReg <= winner ? r1_srcb : r0_srcb;
                saReg   <= winner ? r1_sa   : r0_sa;
                aReg    <= winner ? r1_a    : r0_a;
                bReg    <= winner ? r1_b    : r0_b;
                immReg  <= winner ? r1_imm  : r0_imm;
            end
            if (state == ST_EXEC) begin
                rsp_result <= aluResult;
                rsp_zero   <= aluZero;
            end
            // Completion hands priority to the other requester.
            if (rspDone) begin
                prio <= ~grant;
                if (op_count != {CNT_W{1'b1}}) begin
                    op_count <= op_count + 1'b1;
                end
            end
        end
    end

    assign aluA = srcaReg ? {27'd0, saReg} : aReg;
    assign aluB = srcbReg ? immReg : bReg;

    alu_share_arbiter_alu uAlu (
        .op     (opReg),
        .a      (aluA),
        .b      (aluB),
        .result (aluResult),
        .zero   (aluZero)
    );

    assign rsp_valid = (state == ST_RESP) ? oneHot(grant) : 2'b00;
    assign busy      = (state != ST_IDLE);
    assign dbgState  = state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter against a transaction-level model of
// arbitration, ALU arithmetic and the completion counter.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    reqValid, reqReady, rspValid, rspReady;
    logic [2:0]    tOp   [2];
    logic          tSrca [2];
    logic          tSrcb [2];
    logic [4:0]    tSa   [2];
    logic [31:0]   tA    [2];
    logic [31:0]   tB    [2];
    logic [31:0]   tImm  [2];
    logic [31:0]   result;
    logic          zero, busy;
    logic [CW-1:0] opCount;
    logic [1:0]    dbgState;

    int            nChecks = 0;
    int            nErrors = 0;
    logic          mPrio;
    int            mCount;
    logic [31:0]   lastResult;
    logic          lastWinner;

    always #5 clk = ~clk;

    alu_share_arbiter #(.PRIO_RESET(0), .CNT_W(CW)) dut (
        .CLK        (clk),
        .Reset      (rst),
        .req_valid  (reqValid),
        .req_ready  (reqReady),
        .r0_op      (tOp[0]),
        .r1_op      (tOp[1]),
        .r0_srca    (tSrca[0]),
        .r1_srca    (tSrca[1]),
        .r0_srcb    (tSrcb[0]),
        .r1_srcb    (tSrcb[1]),
        .r0_sa      (tSa[0]),
        .r1_sa      (tSa[1]),
        .r0_a       (tA[0]),
        .r1_a       (tA[1]),
        .r0_b       (tB[0]),
        .r1_b       (tB[1]),
        .r0_imm     (tImm[0]),
        .r1_imm     (tImm[1]),
        .rsp_valid  (rspValid),
        .rsp_ready  (rspReady),
        .rsp_result (result),
        .rsp_zero   (zero),
        .busy       (busy),
        .op_count   (opCount),
        .dbgState   (dbgState)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refAlu(input int i);
        logic [31:0] x, y;
        x = tSrca[i] ? 32'(tSa[i]) : tA[i];
        y = tSrcb[i] ? tImm[i] : tB[i];
        case (tOp[i])
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return (x >= 32) ? 32'd0 : (y << x[4:0]);
            3'd3: return x | y;
            3'd4: return x & y;
            3'd5: return (x < y) ? 32'd1 : 32'd0;
            3'd6: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return x ^ y;
        endcase
    endfunction

    task automatic randFields(input int i);
        tOp[i]   = 3'($urandom_range(0, 7));
        tSrca[i] = 1'($urandom_range(0, 1));
        tSrcb[i] = 1'($urandom_range(0, 1));
        tSa[i]   = 5'($urandom);
        tA[i]    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        tB[i]    = ($urandom_range(0, 3) == 0) ? tA[i] : $urandom;
        tImm[i]  = $urandom;
    endtask

    task automatic setFields(input int i, input logic [2:0] op, input logic srca, input logic [4:0] sa,
                             input logic srcb, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm);
        tOp[i] = op; tSrca[i] = srca; tSa[i] = sa; tSrcb[i] = srcb;
        tA[i] = a; tB[i] = b; tImm[i] = imm;
    endtask

    task automatic doReset();
        rst = 1'b1;
        reqValid = 2'b00;
        rspReady = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mPrio = 1'b0;
        mCount = 0;
        #1;
        check("rst_req_ready", reqReady, 2'b00);
        check("rst_rsp_valid", rspValid, 2'b00);
        check("rst_result", result, 32'd0);
        check("rst_zero", zero, 1'b0);
        check("rst_op_count", opCount, 0);
        check("rst_busy", busy, 1'b0);
    endtask

    // Starts and ends just after a falling edge with the DUT idle.
    task automatic runTxn(input logic [1:0] vmask, input int holdCycles);
        logic        w;
        logic [31:0] expRes;
        reqValid = vmask;
        rspReady = 2'b00;
        #1;
        w = (vmask == 2'b11) ? mPrio : vmask[1];
        expRes = refAlu(int'(w));
        check("req_ready", reqReady, oneHot(w));
        check("state_idle", dbgState, ST_IDLE);
        @(posedge clk);
        @(negedge clk);
        // Inputs after accept must not matter.
        randFields(0);
        randFields(1);
        reqValid = 2'($urandom);
        #1;
        check("busy_exec", busy, 1'b1);
        check("rsp_valid_exec", rspValid, 2'b00);
        check("req_ready_exec", reqReady, 2'b00);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rsp_valid", rspValid, oneHot(w));
        check("rsp_result", result, expRes);
        check("rsp_zero", zero, expRes == 32'd0);
        for (int h = 0; h < holdCycles; h++) begin
            rspReady = ~oneHot(w);
            reqValid = 2'($urandom);
            @(posedge clk);
            @(negedge clk);
            #1;
            check("hold_rsp_valid", rspValid, oneHot(w));
            check("hold_result", result, expRes);
            check("hold_req_ready", reqReady, 2'b00);
            check("hold_busy", busy, 1'b1);
        end
        rspReady = oneHot(w);
        @(posedge clk);
        @(negedge clk);
        rspReady = 2'b00;
        reqValid = 2'b00;
        #1;
        mPrio = ~w;
        mCount = (mCount < (1 << CW) - 1) ? mCount + 1 : mCount;
        check("done_busy", busy, 1'b0);
        check("done_rsp_valid", rspValid, 2'b00);
        check("op_count", opCount, mCount);
        lastResult = result;
        lastWinner = w;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) randFields(i);
        doReset();

        setFields(0, 3'd0, 1'b0, 5'd0, 1'b0, 32'd5, 32'd7, 32'd0);
        runTxn(2'b01, 0);
        check("dir_add", lastResult, 32'd12);
        check("dir_add_count", opCount, 1);

        setFields(1, 3'd1, 1'b0, 5'd0, 1'b0, 32'd9, 32'd9, 32'd0);
        runTxn(2'b10, 1);
        check("dir_sub", lastResult, 32'd0);

        doReset();
        for (int k = 0; k < 3; k++) begin
            setFields(0, 3'd3, 1'b0, 5'd0, 1'b0, 32'hF0, 32'h0F, 32'd0);
            setFields(1, 3'd7, 1'b0, 5'd0, 1'b0, 32'hFF, 32'h0F, 32'd0);
            runTxn(2'b11, 0);
            check("dir_rr_winner", lastWinner, (k == 1) ? 1'b1 : 1'b0);
            check("dir_rr_result", lastResult, (k == 1) ? 32'hF0 : 32'hFF);
        end

        setFields(0, 3'd2, 1'b1, 5'd4, 1'b1, 32'd0, 32'd0, 32'd1);
        runTxn(2'b01, 0);
        check("dir_sll", lastResult, 32'd16);
        setFields(1, 3'd6, 1'b0, 5'd0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0);
        runTxn(2'b10, 0);
        check("dir_slt", lastResult, 32'd1);
        setFields(1, 3'd5, 1'b0, 5'd0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0);
        runTxn(2'b10, 0);
        check("dir_sltu", lastResult, 32'd0);

        randFields(0);
        runTxn(2'b01, 5);
        randFields(1);
        runTxn(2'b10, 0);

        // Reset while an operation sits in EXEC.
        randFields(0);
        reqValid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        reqValid = 2'b00;
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", rspValid, 2'b00);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_op_count", opCount, 0);
        @(negedge clk);
        rst = 1'b0;
        mPrio = 1'b0;
        mCount = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("post_rst_rsp_valid", rspValid, 2'b00);
            check("post_rst_state", dbgState, ST_IDLE);
        end

        // Long enough to saturate the narrow counter.
        for (int t = 0; t < 24; t++) begin
            randFields(0);
            randFields(1);
            runTxn(2'($urandom_range(1, 3)), $urandom_range(0, 3));
        end
        check("sat_op_count", opCount, (1 << CW) - 1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
